// File: rtl/serial_add_ctrl_pkg.sv
// Shared types for the bit-serial adder controller.
// State encoding: IDLE=0, RUN=1, DONE=2.
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
// Combinational; used as the 1-bit datapath of the serial adder.
module full_adder (
  output logic s,
  output logic c_out,
  input  logic a,
  input  logic b,
  input  logic c_in
);

  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder reused over WIDTH cycles, LSB first.
// Optional signed-overflow output enabled by SERIAL_ADD_OVF_EN.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             fa_s, fa_c;

  full_adder u_fa (
    .s     (fa_s),
    .c_out (fa_c),
    .a     (a_q[0]),
    .b     (b_q[0]),
    .c_in  (carry_q)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sh_d    = {fa_s, sh_q[WIDTH-1:1]};
        carry_d = fa_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          sum_d   = {fa_s, sh_q[WIDTH-1:1]};
          cout_d  = fa_c;
          // carry_q here is the carry into the MSB
          ovf_d   = carry_q ^ fa_c;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign c_out = cout_q;

`ifdef SERIAL_ADD_OVF_EN
  assign ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8).
// Checks ovf as well when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         busy, done, c_out;
  logic [W-1:0] sum;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Transaction-level model: an accepted add completes W edges later.
  logic       m_busy, m_done, m_ovf;
  logic [W:0] m_res, m_pend;
  logic       m_povf;
  int         m_rem;

  function automatic logic sovf(logic [W-1:0] x, logic [W-1:0] y, logic ci);
    int s;
    s = int'($signed(x)) + int'($signed(y)) + int'(ci);
    return (s > 127) || (s < -128);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_res  <= '0;
      m_pend <= '0;
      m_rem  <= 0;
      m_ovf  <= 1'b0;
      m_povf <= 1'b0;
    end else if (m_busy) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_res  <= m_pend;
        m_ovf  <= m_povf;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_busy <= 1'b1;
        m_rem  <= W;
        m_pend <= {1'b0, a} + {1'b0, b} + 9'(c_in);
        m_povf <= sovf(a, b, c_in);
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("sum", 32'(sum), 32'(m_res[W-1:0]));
      chk("c_out", 32'(c_out), 32'(m_res[W]));
`ifdef SERIAL_ADD_OVF_EN
      chk("ovf", 32'(ovf), 32'(m_ovf));
`endif
      if (done) done_cnt++;
    end
  end

  task automatic wait_done(string name, output int n);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_lat"}, 32'(n), 32'(W));
  endtask

  task automatic op(string name, logic [W-1:0] x, logic [W-1:0] y,
                    logic ci, logic [W-1:0] es, logic ec);
    int n;
    @(negedge clk);
    a = x; b = y; c_in = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~x; b = ~y; c_in = ~ci;
    chk({name, "_busy"}, 32'(busy), 32'd1);
    wait_done(name, n);
    chk({name, "_sum"}, 32'(sum), 32'(es));
    chk({name, "_cout"}, 32'(c_out), 32'(ec));
  endtask

  initial begin
    int n;
    int d0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(c_out), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    op("t0f01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
    op("tff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    op("t0000c", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
    op("tfffc", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // start held through DONE: second add begins with no idle cycle
    @(negedge clk);
    a = 8'h0F; b = 8'h01; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'h55; b = 8'hAA;
    wait_done("b2b1", n);
    chk("b2b1_sum", 32'(sum), 32'h10);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_nogap", 32'(busy), 32'd1);
    wait_done("b2b2", n);
    chk("b2b2_sum", 32'(sum), 32'hFF);
    chk("b2b2_cout", 32'(c_out), 32'd0);

    // start while busy is ignored
    @(negedge clk);
    d0 = done_cnt;
    a = 8'h10; b = 8'h20; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'h01; b = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ign_sum", 32'(sum), 32'h30);
    repeat (12) @(negedge clk);
    chk("ign_pulses", 32'(done_cnt - d0), 32'd1);

    // reset mid-run aborts with outputs cleared at once
    @(negedge clk);
    d0 = done_cnt;
    a = 8'h33; b = 8'h44; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_sum", 32'(sum), 32'd0);
    chk("mid_cout", 32'(c_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("mid_nodone", 32'(done_cnt - d0), 32'd0);
    op("post_rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

`ifdef SERIAL_ADD_OVF_EN
    op("ovf7f", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
    chk("ovf7f_ovf", 32'(ovf), 32'd1);
    op("ovfff", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    chk("ovfff_ovf", 32'(ovf), 32'd0);
    op("ovf80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
    chk("ovf80_ovf", 32'(ovf), 32'd1);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
